// File: rtl/seq_detector_p.sv
// seq_detector_p
//   Parametrised symbol-sequence detector. Tracks how many symbols of a
//   run-time loaded pattern have been seen, falling back on a mismatch to
//   the longest suffix of recent history that is still a pattern prefix.
//   Emits a registered one-cycle match pulse per completed pattern, with
//   overlapping or non-overlapping detection selectable per symbol.
//
// Ports
//   CLK         in   rising-edge clock
//   nRESET      in   asynchronous active-low reset
//   load        in   capture pattern_in and restart detection (wins over in_valid)
//   pattern_in  in   SYM_W*DEPTH, symbol i at [i*SYM_W +: SYM_W], symbol 0 first
//   overlap     in   1: overlapping detection, 0: restart after each match
//   in_valid    in   Data_in accepted this cycle
//   Data_in     in   SYM_W input symbol
//   state       out  number of pattern symbols currently matched (0..DEPTH-1)
//   match       out  one-cycle pulse after the edge that completed the pattern
//   match_cnt   out  saturating match counter
//
// Build option
//   SEQDET_MATCH_CNT_EN  defined: match_cnt counter is built.
//                        undefined: match_cnt is tied to 0.
//
// state | meaning
// ------+--------------------------------------------------------------
//   0   | no pattern prefix pending
//   k   | last k accepted symbols equal pattern symbols 0..k-1
//
// The full-match condition never appears in state: it shows up only as
// the match pulse, with state already holding the overlap fallback (or 0).

module seq_detector_p #(
  parameter int SYM_W   = 2,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int STATE_W = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   nRESET,
  input  logic                   load,
  input  logic [SYM_W*DEPTH-1:0] pattern_in,
  input  logic                   overlap,
  input  logic                   in_valid,
  input  logic [SYM_W-1:0]       Data_in,
  output logic [STATE_W-1:0]     state,
  output logic                   match,
  output logic [CNT_W-1:0]       match_cnt
);

  localparam int HIST_N = DEPTH - 1;
  localparam int LEN_W  = $clog2(DEPTH);

  logic [SYM_W*DEPTH-1:0] pattern_q, pattern_d;
  // hist_q[0] is the most recently accepted symbol.
  logic [SYM_W-1:0]       hist_q [HIST_N];
  logic [SYM_W-1:0]       hist_d [HIST_N];
  logic [LEN_W-1:0]       hist_len_q, hist_len_d;
  logic [STATE_W-1:0]     state_q, state_d;
  logic                   match_q, match_d;

  // Candidate window: the incoming symbol followed by history, newest first.
  logic [SYM_W-1:0]       win [DEPTH];
  // hit[j]: the newest j symbols (including Data_in) equal pattern prefix j.
  logic [DEPTH:1]         hit;
  // Longest proper prefix (< DEPTH) that is also a suffix of the window.
  logic [STATE_W-1:0]     k_part;

  always_comb begin
    win[0] = Data_in;
    for (int p = 1; p < DEPTH; p++) begin
      win[p] = hist_q[p-1];
    end
  end

  always_comb begin
    hit = '0;
    for (int j = 1; j <= DEPTH; j++) begin
      hit[j] = (j <= int'(hist_len_q) + 1);
      for (int m = 0; m < j; m++) begin
        if (win[j-1-m] != pattern_q[m*SYM_W +: SYM_W]) begin
          hit[j] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    k_part = '0;
    for (int j = 1; j < DEPTH; j++) begin
      if (hit[j]) begin
        k_part = STATE_W'(j);
      end
    end
  end

  always_comb begin
    pattern_d  = pattern_q;
    hist_d     = hist_q;
    hist_len_d = hist_len_q;
    state_d    = state_q;
    match_d    = 1'b0;
    if (load) begin
      pattern_d  = pattern_in;
      for (int i = 0; i < HIST_N; i++) begin
        hist_d[i] = '0;
      end
      hist_len_d = '0;
      state_d    = '0;
    end else if (in_valid) begin
      match_d = hit[DEPTH];
      if (hit[DEPTH] && !overlap) begin
        // Non-overlapping: the completed pattern consumes its symbols.
        for (int i = 0; i < HIST_N; i++) begin
          hist_d[i] = '0;
        end
        hist_len_d = '0;
        state_d    = '0;
      end else begin
        hist_d[0] = Data_in;
        for (int i = 1; i < HIST_N; i++) begin
          hist_d[i] = hist_q[i-1];
        end
        if (hist_len_q != LEN_W'(HIST_N)) begin
          hist_len_d = hist_len_q + 1'b1;
        end
        state_d = k_part;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      pattern_q  <= '0;
      for (int i = 0; i < HIST_N; i++) begin
        hist_q[i] <= '0;
      end
      hist_len_q <= '0;
      state_q    <= '0;
      match_q    <= 1'b0;
    end else begin
      pattern_q  <= pattern_d;
      hist_q     <= hist_d;
      hist_len_q <= hist_len_d;
      state_q    <= state_d;
      match_q    <= match_d;
    end
  end

  assign state = state_q;
  assign match = match_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (in_valid && hit[DEPTH] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule
